// File: rtl/line_follower_pwm_fsm.sv
// rtl/line_follower_pwm_fsm.sv - line-follower H-bridge drive FSM with sensor debounce, dead-time and PWM
// Optional soft-start duty ramp is enabled by defining SOFT_START_EN.
module line_follower_pwm_fsm #(
  parameter int PERIOD       = 10000,
  parameter int DUTY_W       = 14,
  parameter int DEBOUNCE_CYC = 16,
  parameter int DEADTIME_CYC = 8,
  parameter int RAMP_STEP    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [2:0]        sens_i,
  input  logic [DUTY_W-1:0] duty_i,
  output logic [3:0]        mot_o,
  output logic [2:0]        state_o,
  output logic              pwm_o
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int DT_W  = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;

  localparam logic [2:0] S_STANDBY = 3'd0;
  localparam logic [2:0] S_FWD     = 3'd1;
  localparam logic [2:0] S_RIGHT   = 3'd2;
  localparam logic [2:0] S_LEFT    = 3'd3;
  localparam logic [2:0] S_DEAD    = 3'd4;

  if (PERIOD < 2 || DEBOUNCE_CYC < 1 || DEADTIME_CYC < 0 || RAMP_STEP < 1) begin : g_param_check
    $error("line_follower_pwm_fsm: illegal parameter value");
  end

  logic [2:0]        r_sync1;
  logic [2:0]        r_sync2;
  logic [2:0]        r_filt;
  logic [DB_W-1:0]   r_db [3];
  logic [2:0]        r_state;
  logic [2:0]        r_saved;
  logic [DT_W-1:0]   r_dead_cnt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DUTY_W-1:0] r_duty;
  logic [3:0]        r_mot;

  logic [2:0]        w_target;
  logic [2:0]        w_state_next;
  logic [2:0]        w_saved_next;
  logic [DT_W-1:0]   w_dead_next;
  logic [3:0]        w_dir;
  logic              w_wrap;
  logic              w_pwm;
  logic [DUTY_W-1:0] w_eff_duty;

  // A filtered bit flips only after the synced value has disagreed with it for DEBOUNCE_CYC cycles in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_filt  <= 3'b000;
      for (int b = 0; b < 3; b++) r_db[b] <= '0;
    end else begin
      r_sync1 <= sens_i;
      r_sync2 <= r_sync1;
      for (int b = 0; b < 3; b++) begin
        if (r_sync2[b] == r_filt[b]) begin
          r_db[b] <= '0;
        end else if (r_db[b] == DB_W'(DEBOUNCE_CYC - 1)) begin
          r_filt[b] <= r_sync2[b];
          r_db[b]   <= '0;
        end else begin
          r_db[b] <= r_db[b] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_target = S_FWD;
    if (!en || r_filt == 3'b111) begin
      w_target = S_STANDBY;
    end else begin
      case (r_filt)
        3'b001, 3'b101:         w_target = S_LEFT;
        3'b010, 3'b110, 3'b100: w_target = S_RIGHT;
        default:                w_target = S_FWD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_STANDBY;
      r_saved    <= S_STANDBY;
      r_dead_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_saved    <= w_saved_next;
      r_dead_cnt <= w_dead_next;
    end
  end

  // DEAD always completes to the target captured on entry; a newer target is picked up afterwards.
  always_comb begin
    w_state_next = r_state;
    w_saved_next = r_saved;
    w_dead_next  = r_dead_cnt;
    if (r_state == S_DEAD) begin
      if (r_dead_cnt == '0) w_state_next = r_saved;
      else                  w_dead_next  = r_dead_cnt - 1'b1;
    end else if (w_target != r_state) begin
      if (DEADTIME_CYC == 0) begin
        w_state_next = w_target;
      end else begin
        w_state_next = S_DEAD;
        w_saved_next = w_target;
        w_dead_next  = DT_W'(DEADTIME_CYC - 1);
      end
    end
  end

  always_comb begin
    w_dir = 4'b0000;
    case (r_state)
      S_FWD:   w_dir = 4'b1010;
      S_RIGHT: w_dir = 4'b1001;
      S_LEFT:  w_dir = 4'b0110;
      default: w_dir = 4'b0000;
    endcase
  end

  assign w_wrap = (r_cnt == CNT_W'(PERIOD - 1));
  assign w_pwm  = (32'(r_cnt) < 32'(r_duty));

`ifdef SOFT_START_EN
  logic [DUTY_W-1:0] r_ramp;
  logic [DUTY_W:0]   w_ramp_sum;
  logic              w_driving;

  assign w_driving  = (r_state != S_STANDBY) && (r_state != S_DEAD);
  assign w_ramp_sum = {1'b0, r_ramp} + (DUTY_W + 1)'(RAMP_STEP);
  // The next ramp step is what gets latched at the wrap, so the first full period already runs at RAMP_STEP.
  assign w_eff_duty = !w_driving ? '0 :
                      (w_ramp_sum >= {1'b0, duty_i}) ? duty_i : w_ramp_sum[DUTY_W-1:0];

  always_ff @(posedge clk) begin
    if (reset || !w_driving) r_ramp <= '0;
    else if (w_wrap)         r_ramp <= w_eff_duty;
  end
`else
  assign w_eff_duty = duty_i;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_mot  <= 4'b0000;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) r_duty <= w_eff_duty;
      r_mot <= w_dir & {4{w_pwm}};
    end
  end

  assign mot_o   = r_mot;
  assign state_o = r_state;
  assign pwm_o   = w_pwm;

endmodule

// File: tb/tb_line_follower_pwm_fsm.sv
// tb/tb_line_follower_pwm_fsm.sv - scoreboard bench for line_follower_pwm_fsm
// A cycle model pushes expected outputs per edge; scenario tasks add targeted checks.
module tb_line_follower_pwm_fsm;

  localparam int PERIOD = 100;
  localparam int DEB    = 4;
  localparam int DEAD   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [2:0]  sens_i = 3'b000;
  logic [13:0] duty_i = 14'd50;
  logic [3:0]  mot_o, mot0;
  logic [2:0]  state_o, state0;
  logic        pwm_o, pwm0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] state;
    logic [3:0] mot;
    logic       pwm;
  } exp_t;
  exp_t sb[$];

  line_follower_pwm_fsm #(.PERIOD(PERIOD), .DUTY_W(14), .DEBOUNCE_CYC(DEB), .DEADTIME_CYC(DEAD), .RAMP_STEP(10)) u_dut (
    .clk(clk), .reset(reset), .en(en), .sens_i(sens_i), .duty_i(duty_i),
    .mot_o(mot_o), .state_o(state_o), .pwm_o(pwm_o));

  line_follower_pwm_fsm #(.PERIOD(PERIOD), .DUTY_W(14), .DEBOUNCE_CYC(DEB), .DEADTIME_CYC(0), .RAMP_STEP(10)) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .sens_i(sens_i), .duty_i(duty_i),
    .mot_o(mot0), .state_o(state0), .pwm_o(pwm0));

  always #5 clk = ~clk;

  // Reference model state (value after the most recent edge)
  logic [2:0] m_s1, m_s2, m_filt, m_state, m_tgt;
  int         m_run [3];
  int         m_age, m_cnt, m_duty;
  logic [3:0] m_mot;

  function automatic logic [2:0] tgt_of(logic [2:0] f, logic e);
    if (!e || f == 3'b111) return 3'd0;
    case (f)
      3'b000, 3'b011: return 3'd1;
      3'b001, 3'b101: return 3'd3;
      default:        return 3'd2;
    endcase
  endfunction

  function automatic logic [3:0] dir_of(logic [2:0] s);
    case (s)
      3'd1:    return 4'b1010;
      3'd2:    return 4'b1001;
      3'd3:    return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_step();
    logic [2:0] n_filt, n_state, n_tgt, t;
    int n_run [3];
    int n_age;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_filt = 0; m_state = 0; m_tgt = 0;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
      m_age = 0; m_cnt = 0; m_duty = 0; m_mot = 0;
    end else begin
      m_mot = (m_cnt < m_duty) ? dir_of(m_state) : 4'b0000;
      n_filt = m_filt;
      for (int b = 0; b < 3; b++) begin
        n_run[b] = (m_s2[b] != m_filt[b]) ? m_run[b] + 1 : 0;
        if (n_run[b] == DEB) begin
          n_filt[b] = m_s2[b];
          n_run[b] = 0;
        end
      end
      t = tgt_of(m_filt, en);
      n_state = m_state; n_tgt = m_tgt; n_age = m_age;
      if (m_state == 3'd4) begin
        n_age = m_age + 1;
        if (n_age == DEAD) n_state = m_tgt;
      end else if (t != m_state) begin
        n_state = 3'd4; n_tgt = t; n_age = 0;
      end
      if (m_cnt == PERIOD - 1) begin
        m_cnt = 0;
        m_duty = duty_i;
      end else begin
        m_cnt = m_cnt + 1;
      end
      m_s2 = m_s1; m_s1 = sens_i;
      m_filt = n_filt; m_state = n_state; m_tgt = n_tgt; m_age = n_age;
      for (int b = 0; b < 3; b++) m_run[b] = n_run[b];
    end
  endtask

  task automatic cyc();
    model_step();
    sb.push_back(exp_t'{m_state, m_mot, (m_cnt < m_duty)});
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic align_period();
    for (int i = 0; i < PERIOD; i++) begin
      if (m_cnt == 0) break;
      cyc();
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({state_o, mot_o, pwm_o} !== {e.state, e.mot, e.pwm}) begin
        errors++;
        $display("FAIL scoreboard t=%0t got state=%0d mot=%b pwm=%b want state=%0d mot=%b pwm=%b",
                 $time, state_o, mot_o, pwm_o, e.state, e.mot, e.pwm);
      end
      checks++;
      if (((mot_o[3] & mot_o[2]) | (mot_o[1] & mot_o[0])) !== 1'b0) begin
        errors++;
        $display("FAIL shoot_through t=%0t mot=%b want no fwd&rev pair", $time, mot_o);
      end
      checks++;
      if (state0 === 3'd4) begin
        errors++;
        $display("FAIL dt0_no_dead t=%0t state0=%0d want !=4", $time, state0);
      end
    end
  end

  task automatic test_reset();
    reset = 1; en = 1; sens_i = 3'b000; duty_i = 14'd50;
    run(3);
    checks++;
    if ({state_o, mot_o, pwm_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs state=%0d mot=%b pwm=%b want 0/0000/0", state_o, mot_o, pwm_o);
    end
  endtask

  task automatic test_fwd_startup();
    int hi, lo;
    reset = 0;
    cyc();
    checks++;
    if (state_o !== 3'd4) begin errors++; $display("FAIL startup_dead state=%0d want 4", state_o); end
    run(DEAD);
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL startup_fwd state=%0d want 1", state_o); end
    align_period();
    hi = 0; lo = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (mot_o === 4'b1010) hi++;
      if (mot_o === 4'b0000) lo++;
      cyc();
    end
    checks++;
    if (hi != 50 || lo != 50) begin errors++; $display("FAIL fwd_gating high=%0d low=%0d want 50/50", hi, lo); end
  endtask

  task automatic test_glitch_and_left();
    int hi;
    sens_i = 3'b001; run(2);
    sens_i = 3'b000; run(10);
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL glitch_reject state=%0d want 1", state_o); end
    sens_i = 3'b001;
    run(2 + DEB);
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL left_latency_early state=%0d want 1", state_o); end
    cyc();
    checks++;
    if (state_o !== 3'd4) begin errors++; $display("FAIL left_dead state=%0d want 4", state_o); end
    run(DEAD);
    checks++;
    if (state_o !== 3'd3) begin errors++; $display("FAIL left_state state=%0d want 3", state_o); end
    align_period();
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (mot_o === 4'b0110) hi++;
      cyc();
    end
    checks++;
    if (hi != 50) begin errors++; $display("FAIL left_gating high=%0d want 50", hi); end
  endtask

  task automatic test_duty();
    int hi;
    align_period();
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i == 30) duty_i = 14'd80;
      hi += int'(pwm_o === 1'b1);
      cyc();
    end
    checks++;
    if (hi != 50) begin errors++; $display("FAIL duty_midperiod high=%0d want 50", hi); end
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin hi += int'(pwm_o === 1'b1); cyc(); end
    checks++;
    if (hi != 80) begin errors++; $display("FAIL duty_80 high=%0d want 80", hi); end
    duty_i = 14'd0;
    run(PERIOD);
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin hi += int'(mot_o !== 4'b0000); cyc(); end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL duty_0 active_cycles=%0d want 0", hi); end
    duty_i = 14'd100;
    run(PERIOD);
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin hi += int'(pwm_o === 1'b1); cyc(); end
    checks++;
    if (hi != 100) begin errors++; $display("FAIL duty_100 high=%0d want 100", hi); end
    duty_i = 14'd200;
    run(PERIOD);
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin hi += int'(pwm_o === 1'b1); cyc(); end
    checks++;
    if (hi != 100) begin errors++; $display("FAIL duty_200 high=%0d want 100", hi); end
    duty_i = 14'd50;
  endtask

  task automatic test_standby();
    sens_i = 3'b010; run(2 + DEB + 1 + DEAD);
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL right_state state=%0d want 2", state_o); end
    sens_i = 3'b111; run(2 + DEB + 1);
    checks++;
    if (state_o !== 3'd4) begin errors++; $display("FAIL s111_dead state=%0d want 4", state_o); end
    run(DEAD + 1);
    checks++;
    if (state_o !== 3'd0 || mot_o !== 4'b0000) begin
      errors++; $display("FAIL s111_standby state=%0d mot=%b want 0/0000", state_o, mot_o);
    end
    sens_i = 3'b010; run(2 + DEB + 1 + DEAD);
    en = 0; cyc();
    checks++;
    if (state_o !== 3'd4) begin errors++; $display("FAIL en0_dead state=%0d want 4", state_o); end
    run(DEAD);
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL en0_standby state=%0d want 0", state_o); end
    en = 1; cyc();
    en = 0; run(DEAD);
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL dead_old_target state=%0d want 2", state_o); end
    cyc();
    checks++;
    if (state_o !== 3'd4) begin errors++; $display("FAIL dead_reenter state=%0d want 4", state_o); end
    run(DEAD);
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL dead_then_standby state=%0d want 0", state_o); end
    en = 1;
  endtask

  task automatic test_deadtime0();
    sens_i = 3'b000; run(12);
    checks++;
    if (state0 !== 3'd1) begin errors++; $display("FAIL dt0_fwd state0=%0d want 1", state0); end
    sens_i = 3'b010; run(2 + DEB);
    checks++;
    if (state0 !== 3'd1) begin errors++; $display("FAIL dt0_early state0=%0d want 1", state0); end
    cyc();
    checks++;
    if (state0 !== 3'd2) begin errors++; $display("FAIL dt0_right state0=%0d want 2", state0); end
    run(20);
  endtask

  task automatic test_reset_mid();
    reset = 1; cyc();
    checks++;
    if ({state_o, mot_o, pwm_o, state0} !== 11'h000) begin
      errors++; $display("FAIL reset_mid state=%0d mot=%b pwm=%b state0=%0d want all 0", state_o, mot_o, pwm_o, state0);
    end
    reset = 0; cyc();
    checks++;
    if (state_o !== 3'd4) begin errors++; $display("FAIL reset_mid_restart state=%0d want 4", state_o); end
    run(150);
  endtask

  initial begin
    test_reset();
    test_fwd_startup();
    test_glitch_and_left();
    test_duty();
    test_standby();
    test_deadtime0();
    test_reset_mid();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
